// File: rtl/fpnew_pkg.sv
// Shared types for the non-computational FP scheduler: formats, rounding
// modes, operations, status/class encodings, the request/response payload
// structs and the width helpers used to size ports.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [9:0] {
        NEGINF     = 10'b00_0000_0001,
        NEGNORM    = 10'b00_0000_0010,
        NEGSUBNORM = 10'b00_0000_0100,
        NEGZERO    = 10'b00_0000_1000,
        POSZERO    = 10'b00_0001_0000,
        POSSUBNORM = 10'b00_0010_0000,
        POSNORM    = 10'b00_0100_0000,
        POSINF     = 10'b00_1000_0000,
        SNAN       = 10'b01_0000_0000,
        QNAN       = 10'b10_0000_0000
    } classmask_e;

    // Control part of an issued request (operands are sized per instance).
    typedef struct packed {
        logic [1:0] is_boxed;
        roundmode_e rnd_mode;
        operation_e op;
        logic       op_mod;
    } req_ctrl_t;

    // Metadata part of a returned result (result word is sized per instance).
    typedef struct packed {
        status_t    status;
        logic       extension_bit;
        classmask_e class_mask;
        logic       is_class;
    } rsp_meta_t;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            FP8:           return 8;
            default:       return 32;
        endcase
    endfunction

    // Tag width: enough bits to name every requester, never less than one.
    function automatic int unsigned tag_width(int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_arb.sv
// Round-robin arbiter with a hold lock: once an offer is made and not yet
// accepted, the same requester stays selected until the handshake or a flush.
module fpnew_rr_arb #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NumReq-1:0] i_valid,
    input  logic            i_issue_valid,
    input  logic            i_issue_ready,
    input  logic            i_flush,
    output logic [IdxW-1:0] o_win_idx
);

    logic [IdxW-1:0] r_rr_ptr;
    logic            r_lock;
    logic [IdxW-1:0] r_lock_idx;
    logic [IdxW-1:0] w_rr_idx;
    logic [IdxW-1:0] w_cand;
    logic            w_found;

    // Scan requesters starting at the pointer, wrapping at NumReq-1.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_rr_idx = '0;
        w_found  = 1'b0;
        w_cand   = r_rr_ptr;
        for (int k = 0; k < int'(NumReq); k++) begin
            if (!w_found && i_valid[w_cand]) begin
                w_found  = 1'b1;
                w_rr_idx = w_cand;
            end
            w_cand = (w_cand == IdxW'(NumReq - 1)) ? '0 : w_cand + 1'b1;
        end
    end

    assign o_win_idx = r_lock ? r_lock_idx : w_rr_idx;

    // Pointer advances past the winner on handshake; lock holds a stalled offer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (i_flush) begin
            r_lock <= 1'b0;
        end else if (i_issue_valid && i_issue_ready) begin
            r_lock   <= 1'b0;
            r_rr_ptr <= (o_win_idx == IdxW'(NumReq - 1)) ? '0 : o_win_idx + 1'b1;
        end else if (i_issue_valid) begin
            r_lock     <= 1'b1;
            r_lock_idx <= o_win_idx;
        end
    end

endmodule

// File: rtl/fpnew_noncomp_sched.sv
// Scheduler sharing one non-computational FP unit among NumReq requesters:
// round-robin issue with zero added latency, tag-routed responses, an
// in-flight limit, flush, and optional per-requester grant counters enabled
// by macro FPNEW_NONCOMP_SCHED_STATS_EN.
module fpnew_noncomp_sched
    import fpnew_pkg::*;
#(
    parameter fp_format_e  FpFormat    = FP32,
    parameter int unsigned NumReq      = 4,
    parameter int unsigned MaxInflight = 2,
    parameter int unsigned CntWidth    = 16,
    localparam int unsigned WIDTH      = fp_width(FpFormat),
    localparam int unsigned TAG_W      = tag_width(NumReq)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq-1:0][1:0][WIDTH-1:0] req_operands_i,
    input  logic [NumReq-1:0][1:0]            req_is_boxed_i,
    input  roundmode_e                        req_rnd_mode_i [NumReq],
    input  operation_e                        req_op_i [NumReq],
    input  logic [NumReq-1:0]                 req_op_mod_i,
    output logic                              unit_in_valid_o,
    input  logic                              unit_in_ready_i,
    output logic [1:0][WIDTH-1:0]             unit_operands_o,
    output logic [1:0]                        unit_is_boxed_o,
    output roundmode_e                        unit_rnd_mode_o,
    output operation_e                        unit_op_o,
    output logic                              unit_op_mod_o,
    output logic [TAG_W-1:0]                  unit_tag_o,
    output logic                              unit_flush_o,
    input  logic                              unit_out_valid_i,
    output logic                              unit_out_ready_o,
    input  logic [WIDTH-1:0]                  unit_result_i,
    input  status_t                           unit_status_i,
    input  logic                              unit_extension_bit_i,
    input  classmask_e                        unit_class_mask_i,
    input  logic                              unit_is_class_i,
    input  logic [TAG_W-1:0]                  unit_tag_i,
    output logic [NumReq-1:0]                 rsp_valid_o,
    input  logic [NumReq-1:0]                 rsp_ready_i,
    output logic [WIDTH-1:0]                  rsp_result_o,
    output status_t                           rsp_status_o,
    output logic                              rsp_extension_bit_o,
    output classmask_e                        rsp_class_mask_o,
    output logic                              rsp_is_class_o,
    input  logic                              flush_i,
    output logic                              busy_o,
    output logic [NumReq-1:0][CntWidth-1:0]   grant_cnt_o
);

    localparam int unsigned INF_W = $clog2(MaxInflight + 1);

    logic [TAG_W-1:0] w_win_idx;
    logic             w_any_valid;
    logic             w_room;
    logic             w_issue_hs;
    logic             w_ret_hs;
    logic [INF_W-1:0] r_inflight;
    req_ctrl_t        w_req_ctrl [NumReq];
    req_ctrl_t        w_issue_ctrl;
    rsp_meta_t        w_rsp_meta;

    fpnew_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (TAG_W)
    ) u_arb (
        .clk           (clk_i),
        .rst_n         (rst_ni),
        .i_valid       (req_valid_i),
        .i_issue_valid (unit_in_valid_o),
        .i_issue_ready (unit_in_ready_i),
        .i_flush       (flush_i),
        .o_win_idx     (w_win_idx)
    );

    // ---------------- issue side ----------------
    assign w_any_valid = |req_valid_i;
    // A full window still admits an issue when a slot frees in the same cycle.
    assign w_room          = (r_inflight < INF_W'(MaxInflight)) | w_ret_hs;
    // Outputs are forced idle while reset is held, not just after it.
    assign unit_in_valid_o = rst_ni & w_any_valid & w_room & ~flush_i;
    assign w_issue_hs      = unit_in_valid_o & unit_in_ready_i;
    assign unit_flush_o    = flush_i;
    assign unit_tag_o      = w_win_idx;

    // Gather each requester's control fields into one struct per requester.
    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            w_req_ctrl[i] = '{is_boxed: req_is_boxed_i[i], rnd_mode: req_rnd_mode_i[i],
                              op: req_op_i[i], op_mod: req_op_mod_i[i]};
        end
    end

    assign w_issue_ctrl    = w_req_ctrl[w_win_idx];
    assign unit_operands_o = req_operands_i[w_win_idx];
    assign unit_is_boxed_o = w_issue_ctrl.is_boxed;
    assign unit_rnd_mode_o = w_issue_ctrl.rnd_mode;
    assign unit_op_o       = w_issue_ctrl.op;
    assign unit_op_mod_o   = w_issue_ctrl.op_mod;

    // Only the winner sees ready, and only on an actual handshake.
    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            req_ready_o[i] = w_issue_hs & (w_win_idx == TAG_W'(i));
        end
    end

    // ---------------- return side ----------------
    // Steer the return to its tag owner; an unknown tag is accepted and dropped.
    always_comb begin
        rsp_valid_o      = '0;
        unit_out_ready_o = 1'b1;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (unit_tag_i == TAG_W'(i)) begin
                rsp_valid_o[i]   = rst_ni & unit_out_valid_i;
                unit_out_ready_o = rsp_ready_i[i];
            end
        end
    end

    assign w_ret_hs   = unit_out_valid_i & unit_out_ready_o;
    assign w_rsp_meta = '{status: unit_status_i, extension_bit: unit_extension_bit_i,
                          class_mask: unit_class_mask_i, is_class: unit_is_class_i};

    assign rsp_result_o        = unit_result_i;
    assign rsp_status_o        = w_rsp_meta.status;
    assign rsp_extension_bit_o = w_rsp_meta.extension_bit;
    assign rsp_class_mask_o    = w_rsp_meta.class_mask;
    assign rsp_is_class_o      = w_rsp_meta.is_class;

    // Count accepted-but-unreturned operations; flush abandons them all.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= '0;
        end else if (flush_i) begin
            r_inflight <= '0;
        end else if (w_issue_hs && !w_ret_hs) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_issue_hs && w_ret_hs && (r_inflight != '0)) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    assign busy_o = rst_ni & ((r_inflight != '0) | w_any_valid);

    // ---------------- statistics ----------------
`ifdef FPNEW_NONCOMP_SCHED_STATS_EN
    logic [NumReq-1:0][CntWidth-1:0] r_grant_cnt;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NumReq); i++) begin
                if (req_ready_o[i] && (r_grant_cnt[i] != '1)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt_o = r_grant_cnt;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpnew_noncomp_sched.sv
// Directed bench for fpnew_noncomp_sched (NumReq=4, MaxInflight=2,
// CntWidth=4). The bench plays both the requesters and the shared unit.
module tb_fpnew_noncomp_sched;
    import fpnew_pkg::*;

    localparam int unsigned NUM_REQ = 4;
`ifdef FPNEW_NONCOMP_SCHED_STATS_EN
    localparam logic [3:0] CNT_AT_10 = 4'd10;
    localparam logic [3:0] CNT_AT_20 = 4'd15;
`else
    localparam logic [3:0] CNT_AT_10 = 4'd0;
    localparam logic [3:0] CNT_AT_20 = 4'd0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [3:0]            req_valid;
    logic [3:0]            req_ready;
    logic [3:0][1:0][31:0] req_operands;
    logic [3:0][1:0]       req_is_boxed;
    roundmode_e            req_rnd_mode [4];
    operation_e            req_op [4];
    logic [3:0]            req_op_mod;
    logic                  unit_in_valid, unit_in_ready;
    logic [1:0][31:0]      unit_operands;
    logic [1:0]            unit_is_boxed;
    roundmode_e            unit_rnd_mode;
    operation_e            unit_op;
    logic                  unit_op_mod;
    logic [1:0]            unit_tag_o, unit_tag_i;
    logic                  unit_flush;
    logic                  unit_out_valid, unit_out_ready;
    logic [31:0]           unit_result;
    status_t               unit_status;
    logic                  unit_ext;
    classmask_e            unit_class_mask;
    logic                  unit_is_class;
    logic [3:0]            rsp_valid, rsp_ready;
    logic [31:0]           rsp_result;
    status_t               rsp_status;
    logic                  rsp_ext;
    classmask_e            rsp_class_mask;
    logic                  rsp_is_class;
    logic                  flush, busy;
    logic [3:0][3:0]       grant_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    roundmode_e rm_tab [4] = '{RNE, RTZ, RDN, RUP};
    operation_e op_tab [4] = '{SGNJ, MINMAX, CMP, CLASSIFY};

    always #5 clk = ~clk;

    fpnew_noncomp_sched #(
        .FpFormat(FP32), .NumReq(NUM_REQ), .MaxInflight(2), .CntWidth(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operands_i(req_operands), .req_is_boxed_i(req_is_boxed),
        .req_rnd_mode_i(req_rnd_mode), .req_op_i(req_op), .req_op_mod_i(req_op_mod),
        .unit_in_valid_o(unit_in_valid), .unit_in_ready_i(unit_in_ready),
        .unit_operands_o(unit_operands), .unit_is_boxed_o(unit_is_boxed),
        .unit_rnd_mode_o(unit_rnd_mode), .unit_op_o(unit_op), .unit_op_mod_o(unit_op_mod),
        .unit_tag_o(unit_tag_o), .unit_flush_o(unit_flush),
        .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
        .unit_result_i(unit_result), .unit_status_i(unit_status),
        .unit_extension_bit_i(unit_ext), .unit_class_mask_i(unit_class_mask),
        .unit_is_class_i(unit_is_class), .unit_tag_i(unit_tag_i),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
        .rsp_extension_bit_o(rsp_ext), .rsp_class_mask_o(rsp_class_mask),
        .rsp_is_class_o(rsp_is_class),
        .flush_i(flush), .busy_o(busy), .grant_cnt_o(grant_cnt)
    );

    // The unit model never produces an out-of-range tag.
    always @(posedge clk) begin
        if (rst_n && unit_out_valid && int'(unit_tag_i) >= int'(NUM_REQ))
            $error("unit returned out-of-range tag %0d", unit_tag_i);
    end

    task automatic set_idle();
        req_valid = '0; unit_in_ready = 1'b0; unit_out_valid = 1'b0;
        unit_tag_i = '0; rsp_ready = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; unit_in_ready = 1'b1;
        unit_out_valid = 1'b1; unit_tag_i = 2'd1; rsp_ready = 4'hF;
        #2;
        n_cmp++; if (unit_in_valid !== 1'b0) begin n_bad++; $display("FAIL rst_in_valid: got %0b want 0", unit_in_valid); end
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'h0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (grant_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_grant_cnt: got %h want 0000", grant_cnt); end
        do_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy: got %0b want 0", busy); end
        // Pointer starts at 0, so the first valid at/after 0 is requester 2.
        req_valid = 4'b0100; unit_in_ready = 1'b1;
        #1;
        n_cmp++; if (unit_tag_o !== 2'd2) begin n_bad++; $display("FAIL post_rst_tag: got %0d want 2", unit_tag_o); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL post_rst_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = '0; unit_in_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL inflight_busy: got %0b want 1", busy); end
        // Reset mid-operation abandons the outstanding op.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abandon_busy: got %0b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int e_idx;
        logic [1:0] rt;
        do_reset();
        req_valid = 4'hF; unit_in_ready = 1'b1; rsp_ready = 4'hF;
        for (int c = 0; c < 5; c++) begin
            e_idx = c % 4;
            rt = 2'(c + 2);
            unit_out_valid = (c >= 2);
            unit_tag_i = rt;
            unit_result = 32'h5000_0000 | 32'(c);
            #1;
            n_cmp++; if (unit_tag_o !== 2'(e_idx)) begin n_bad++; $display("FAIL rr_tag c%0d: got %0d want %0d", c, unit_tag_o, e_idx); end
            n_cmp++; if (req_ready !== 4'(1 << e_idx)) begin n_bad++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, 4'(1 << e_idx)); end
            n_cmp++; if (unit_operands !== {32'hB000_0000 | 32'(e_idx), 32'hA000_0000 | 32'(e_idx)}) begin n_bad++; $display("FAIL rr_operands c%0d: got %h", c, unit_operands); end
            n_cmp++; if (unit_rnd_mode !== rm_tab[e_idx] || unit_op !== op_tab[e_idx]) begin n_bad++; $display("FAIL rr_ctrl c%0d: got %0d/%0d want %0d/%0d", c, unit_rnd_mode, unit_op, rm_tab[e_idx], op_tab[e_idx]); end
            if (c >= 2) begin
                n_cmp++; if (rsp_valid !== 4'(1 << rt) || rsp_result !== (32'h5000_0000 | 32'(c))) begin n_bad++; $display("FAIL rr_rsp c%0d: got %b/%h want %b", c, rsp_valid, rsp_result, 4'(1 << rt)); end
            end
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_valid = 4'b0010; unit_in_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (unit_tag_o !== 2'd1 || unit_in_valid !== 1'b1) begin n_bad++; $display("FAIL lock_tag c%0d: got tag %0d valid %0b want 1/1", c, unit_tag_o, unit_in_valid); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL lock_ready c%0d: got %b want 0000", c, req_ready); end
            n_cmp++; if (unit_operands[0] !== 32'hA000_0001) begin n_bad++; $display("FAIL lock_payload c%0d: got %h want a0000001", c, unit_operands[0]); end
            tick();
            req_valid = 4'b0011;
        end
        unit_in_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_release: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (unit_tag_o !== 2'd0 || req_ready !== 4'b0001) begin n_bad++; $display("FAIL lock_next: got tag %0d ready %b want 0/0001", unit_tag_o, req_ready); end
        tick();
    endtask

    task automatic test_inflight();
        do_reset();
        req_valid = 4'b0001; unit_in_ready = 1'b1; rsp_ready = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL inf_issue c%0d: got %b want 0001", c, req_ready); end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (unit_in_valid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL inf_blocked c%0d: got valid %0b ready %b want 0/0000", c, unit_in_valid, req_ready); end
            tick();
        end
        unit_out_valid = 1'b1; unit_tag_i = 2'd0;
        #1;
        n_cmp++; if (unit_in_valid !== 1'b1 || req_ready !== 4'b0001) begin n_bad++; $display("FAIL inf_swap_issue: got valid %0b ready %b want 1/0001", unit_in_valid, req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0001 || unit_out_ready !== 1'b1) begin n_bad++; $display("FAIL inf_swap_ret: got rsp %b ready %0b want 0001/1", rsp_valid, unit_out_ready); end
        tick();
        unit_out_valid = 1'b0;
        #1;
        n_cmp++; if (unit_in_valid !== 1'b0) begin n_bad++; $display("FAIL inf_still_full: got %0b want 0", unit_in_valid); end
        unit_in_ready = 1'b0; unit_out_valid = 1'b1;
        tick();
        unit_out_valid = 1'b0;
        #1;
        n_cmp++; if (unit_in_valid !== 1'b1) begin n_bad++; $display("FAIL inf_after_ret: got %0b want 1", unit_in_valid); end
    endtask

    task automatic test_rsp_backpressure();
        do_reset();
        req_valid = 4'b0100; unit_in_ready = 1'b1;
        tick();
        req_valid = '0; unit_in_ready = 1'b0;
        unit_out_valid = 1'b1; unit_tag_i = 2'd2; rsp_ready = 4'b0000;
        unit_result = 32'hDEAD_BEEF; unit_status = '{nv: 1'b1, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b1};
        unit_ext = 1'b1; unit_class_mask = POSINF; unit_is_class = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rsp_ready = 4'b1011;
            #1;
            n_cmp++; if (rsp_valid !== 4'b0100 || unit_out_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold c%0d: got rsp %b ready %0b want 0100/0", c, rsp_valid, unit_out_ready); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy c%0d: got %0b want 1", c, busy); end
            tick();
        end
        n_cmp++; if (rsp_result !== 32'hDEAD_BEEF || rsp_status !== 5'b10001 || rsp_ext !== 1'b1) begin n_bad++; $display("FAIL bp_payload: got %h/%b/%0b", rsp_result, rsp_status, rsp_ext); end
        n_cmp++; if (rsp_class_mask !== POSINF || rsp_is_class !== 1'b1) begin n_bad++; $display("FAIL bp_class: got %h/%0b want 080/1", rsp_class_mask, rsp_is_class); end
        rsp_ready = 4'b0100;
        #1;
        n_cmp++; if (unit_out_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %0b want 1", unit_out_ready); end
        tick();
        unit_out_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_done: got busy %0b rsp %b want 0/0000", busy, rsp_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b0011; unit_in_ready = 1'b1;
        tick();
        tick();
        req_valid = 4'b0100; flush = 1'b1;
        #1;
        n_cmp++; if (unit_flush !== 1'b1) begin n_bad++; $display("FAIL flush_out: got %0b want 1", unit_flush); end
        n_cmp++; if (unit_in_valid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_block: got valid %0b ready %b want 0/0000", unit_in_valid, req_ready); end
        tick();
        flush = 1'b0; req_valid = '0;
        #1;
        n_cmp++; if (busy !== 1'b0 || unit_flush !== 1'b0) begin n_bad++; $display("FAIL flush_after: got busy %0b flush %0b want 0/0", busy, unit_flush); end
        // Two grants (0,1) left the pointer at 2, and flush keeps it there.
        req_valid = 4'hF;
        #1;
        n_cmp++; if (unit_in_valid !== 1'b1 || unit_tag_o !== 2'd2) begin n_bad++; $display("FAIL flush_ptr: got valid %0b tag %0d want 1/2", unit_in_valid, unit_tag_o); end
    endtask

    task automatic test_stats();
        do_reset();
        req_valid = 4'b1000; unit_in_ready = 1'b1; rsp_ready = 4'hF; unit_tag_i = 2'd3;
        for (int g = 0; g < 20; g++) begin
            unit_out_valid = (g > 0);
            #1;
            n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL stats_grant g%0d: got %b want 1000", g, req_ready); end
            tick();
            if (g == 9) begin
                n_cmp++; if (grant_cnt[3] !== CNT_AT_10) begin n_bad++; $display("FAIL stats_cnt10: got %0d want %0d", grant_cnt[3], CNT_AT_10); end
            end
        end
        req_valid = '0; unit_out_valid = 1'b1;
        #1;
        n_cmp++; if (grant_cnt[3] !== CNT_AT_20) begin n_bad++; $display("FAIL stats_sat: got %0d want %0d", grant_cnt[3], CNT_AT_20); end
        n_cmp++; if (grant_cnt[2:0] !== 12'h000) begin n_bad++; $display("FAIL stats_others: got %h want 000", grant_cnt[2:0]); end
        tick();
        unit_out_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stats_drain: got %0b want 0", busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_operands[i][0] = 32'hA000_0000 | 32'(i);
            req_operands[i][1] = 32'hB000_0000 | 32'(i);
            req_is_boxed[i]    = 2'(i);
            req_rnd_mode[i]    = rm_tab[i];
            req_op[i]          = op_tab[i];
            req_op_mod[i]      = 1'(i & 1);
        end
        unit_result = '0; unit_status = '0; unit_ext = 1'b0;
        unit_class_mask = POSZERO; unit_is_class = 1'b0;
        set_idle();
        test_reset();
        test_round_robin();
        test_lock();
        test_inflight();
        test_rsp_backpressure();
        test_flush();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
